// File: rtl/core_pkg.sv
// core_pkg: shared opcode map, immediate-type codes and decode control bundle for the RV32I core
package core_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd7
    } imm_t;

    typedef struct packed {
        imm_t imm_type;
        logic reg_wen;
        logic mem_rd;
        logic mem_wr;
        logic alu_src_imm;
        logic illegal;
        logic use_rs1;
        logic use_rs2;
    } dec_t;

endpackage

// File: rtl/decode_ctrl_if.sv
// decode_ctrl_if: fetch-to-decode valid/ready instruction handshake
interface decode_ctrl_if #(parameter int XLEN = 32);
    logic            if_valid;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;

    modport master (output if_valid, if_inst, if_pc, input if_ready);
    modport slave  (input if_valid, if_inst, if_pc, output if_ready);
endinterface

// File: rtl/decode_ctrl_inst_decoder.sv
// inst_decoder: combinational opcode decode into immediate type, datapath controls and register usage
module inst_decoder
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rd,
    output dec_t       dec
);
    always_comb begin
        dec          = '0;
        dec.imm_type = IMM_NONE;
        case (opcode)
            OP_LOAD: begin
                dec.imm_type = IMM_I;
                dec.mem_rd   = 1'b1;
                dec.reg_wen  = 1'b1;
                dec.use_rs1  = 1'b1;
            end
            OP_IMM, OP_JALR, OP_SYSTEM: begin
                dec.imm_type = IMM_I;
                dec.reg_wen  = 1'b1;
                dec.use_rs1  = 1'b1;
            end
            OP_STORE: begin
                dec.imm_type = IMM_S;
                dec.mem_wr   = 1'b1;
                dec.use_rs1  = 1'b1;
                dec.use_rs2  = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm_type = IMM_B;
                dec.use_rs1  = 1'b1;
                dec.use_rs2  = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec.imm_type = IMM_U;
                dec.reg_wen  = 1'b1;
            end
            OP_JAL: begin
                dec.imm_type = IMM_J;
                dec.reg_wen  = 1'b1;
            end
            OP_OP: begin
                dec.reg_wen  = 1'b1;
                dec.use_rs1  = 1'b1;
                dec.use_rs2  = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // writes to x0 are architecturally discarded, so never report them
        dec.reg_wen     = dec.reg_wen & (|rd);
        dec.alu_src_imm = dec.imm_type inside {IMM_I, IMM_S, IMM_U};
    end
endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: ID pipeline register with handshake, flush, load-use bubble insertion and bubble counter
module decode_ctrl
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    decode_ctrl_if.slave     fe,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_inst,
    output logic [XLEN-1:0]  id_pc,
    output logic [2:0]       id_imm_type,
    output logic             id_reg_wen,
    output logic             id_mem_rd,
    output logic             id_mem_wr,
    output logic             id_alu_src_imm,
    output logic             id_illegal,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t     state, state_nxt;
    dec_t       id_dec, if_dec;
    logic       advance, load, bubble, rs1_hit, rs2_hit;
    logic [4:0] id_rd, if_rs1, if_rs2;
    logic       unused;

    inst_decoder u_id_dec (.opcode(id_inst[6:0]), .rd(id_inst[11:7]), .dec(id_dec));
    inst_decoder u_if_dec (.opcode(fe.if_inst[6:0]), .rd(fe.if_inst[11:7]), .dec(if_dec));

    assign id_rd  = id_inst[11:7];
    assign if_rs1 = fe.if_inst[19:15];
    assign if_rs2 = fe.if_inst[24:20];

    assign rs1_hit      = if_dec.use_rs1 & (if_rs1 == id_rd);
    assign rs2_hit      = if_dec.use_rs2 & (if_rs2 == id_rd);
    assign hazard_stall = id_valid & id_dec.mem_rd & (|id_rd) & fe.if_valid & (rs1_hit | rs2_hit) & !flush;
    assign advance      = !id_valid | ex_ready;
    assign fe.if_ready  = advance & !hazard_stall & !flush;

    assign id_valid       = state == FULL;
    assign id_imm_type    = id_dec.imm_type;
    assign id_reg_wen     = id_dec.reg_wen;
    assign id_mem_rd      = id_dec.mem_rd;
    assign id_mem_wr      = id_dec.mem_wr;
    assign id_alu_src_imm = id_dec.alu_src_imm;
    assign id_illegal     = id_dec.illegal;

    assign unused = ^{id_dec.use_rs1, id_dec.use_rs2, if_dec.imm_type, if_dec.reg_wen, if_dec.mem_rd,
                      if_dec.mem_wr, if_dec.alu_src_imm, if_dec.illegal, fe.if_inst};

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        bubble    = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else if (hazard_stall && ex_ready) begin
            state_nxt = EMPTY;
            bubble    = 1'b1;
        end else if (fe.if_valid && fe.if_ready) begin
            state_nxt = FULL;
            load      = 1'b1;
        end else if (advance) begin
            state_nxt = EMPTY;
        end
    end

    // inst/pc are kept through flush and bubble; consumers qualify with id_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            id_inst    <= XLEN'(NOP);
            id_pc      <= '0;
            bubble_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                id_inst <= fe.if_inst;
                id_pc   <= fe.if_pc;
            end
            if (bubble)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed-vector bench for decode_ctrl with hand-computed expectations
module tb_decode_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [2:0]  id_imm_type;
    logic        id_reg_wen;
    logic        id_mem_rd;
    logic        id_mem_wr;
    logic        id_alu_src_imm;
    logic        id_illegal;
    logic        hazard_stall;
    logic [31:0] bubble_cnt;
    int          n_vec = 0;
    int          n_bad = 0;

    decode_ctrl_if #(.XLEN(32)) fe ();

    decode_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .fe(fe), .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_imm_type(id_imm_type),
        .id_reg_wen(id_reg_wen), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .id_alu_src_imm(id_alu_src_imm), .id_illegal(id_illegal),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        fe.if_valid = v;
        fe.if_inst  = inst;
        fe.if_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_inst", id_inst, 32'h0000_0013);
        check("rst_pc", id_pc, 32'h0);
        check("rst_bcnt", bubble_cnt, 32'd0);
        check("rst_imm", {29'b0, id_imm_type}, 32'd0);
        check("rst_wen", {31'b0, id_reg_wen}, 32'd0);
        check("rst_ctl", {28'b0, id_mem_rd, id_mem_wr, id_alu_src_imm ^ 1'b1, id_illegal}, 32'd0);
        check("rst_ready", {31'b0, fe.if_ready}, 32'd1);

        // sw x5,4(x2)
        ex_ready = 1'b1;
        drive(1'b1, 32'h0051_2223, 32'h100);
        tick();
        check("sw_valid", {31'b0, id_valid}, 32'd1);
        check("sw_imm", {29'b0, id_imm_type}, 32'd1);
        check("sw_memwr", {31'b0, id_mem_wr}, 32'd1);
        check("sw_wen", {31'b0, id_reg_wen}, 32'd0);
        check("sw_pc", id_pc, 32'h100);
        check("sw_aluimm", {31'b0, id_alu_src_imm}, 32'd1);

        // lw x5,0(x1) then dependent add x6,x5,x2
        drive(1'b1, 32'h0000_A283, 32'h104);
        tick();
        check("lw_inst", id_inst, 32'h0000_A283);
        check("lw_memrd", {31'b0, id_mem_rd}, 32'd1);
        check("lw_wen", {31'b0, id_reg_wen}, 32'd1);
        drive(1'b1, 32'h0022_8333, 32'h108);
        #1;
        check("lu_stall", {31'b0, hazard_stall}, 32'd1);
        check("lu_ready", {31'b0, fe.if_ready}, 32'd0);
        tick();
        check("lu_bubble_valid", {31'b0, id_valid}, 32'd0);
        check("lu_bcnt", bubble_cnt, 32'd1);
        check("lu_nostall", {31'b0, hazard_stall}, 32'd0);
        tick();
        check("add_valid", {31'b0, id_valid}, 32'd1);
        check("add_inst", id_inst, 32'h0022_8333);
        check("add_imm", {29'b0, id_imm_type}, 32'd7);
        check("add_aluimm", {31'b0, id_alu_src_imm}, 32'd0);

        // lw x5 then independent add x6,x1,x2: back-to-back
        drive(1'b1, 32'h0000_A283, 32'h10C);
        tick();
        drive(1'b1, 32'h0020_8333, 32'h110);
        #1;
        check("ind_stall", {31'b0, hazard_stall}, 32'd0);
        check("ind_ready", {31'b0, fe.if_ready}, 32'd1);
        tick();
        check("ind_inst", id_inst, 32'h0020_8333);
        check("ind_bcnt", bubble_cnt, 32'd1);

        // hazard concurrent with flush
        drive(1'b1, 32'h0000_A283, 32'h114);
        tick();
        drive(1'b1, 32'h0022_8333, 32'h118);
        flush = 1'b1;
        #1;
        check("fl_stall", {31'b0, hazard_stall}, 32'd0);
        check("fl_ready", {31'b0, fe.if_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("fl_valid", {31'b0, id_valid}, 32'd0);
        check("fl_bcnt", bubble_cnt, 32'd1);
        check("fl_dropped", id_inst, 32'h0000_A283);

        // idle fetch empties the stage
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("idle_valid", {31'b0, id_valid}, 32'd0);

        // EX back-pressure for three cycles
        drive(1'b1, 32'h00A0_0093, 32'h200);
        tick();
        ex_ready = 1'b0;
        drive(1'b1, 32'h0010_0113, 32'h204);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", {31'b0, fe.if_ready}, 32'd0);
            tick();
            check("bp_inst", id_inst, 32'h00A0_0093);
            check("bp_pc", id_pc, 32'h200);
            check("bp_valid", {31'b0, id_valid}, 32'd1);
        end
        ex_ready = 1'b1;
        #1;
        check("rel_ready", {31'b0, fe.if_ready}, 32'd1);
        tick();
        check("rel_inst", id_inst, 32'h0010_0113);
        check("rel_pc", id_pc, 32'h204);

        // load-use hazard while EX stalls: no bubble until EX accepts
        drive(1'b1, 32'h0000_A283, 32'h208);
        tick();
        ex_ready = 1'b0;
        drive(1'b1, 32'h0022_8333, 32'h20C);
        #1;
        check("hs_stall", {31'b0, hazard_stall}, 32'd1);
        tick();
        check("hs_hold_valid", {31'b0, id_valid}, 32'd1);
        check("hs_hold_bcnt", bubble_cnt, 32'd1);
        check("hs_hold_inst", id_inst, 32'h0000_A283);
        ex_ready = 1'b1;
        tick();
        check("hs_bubble_valid", {31'b0, id_valid}, 32'd0);
        check("hs_bcnt", bubble_cnt, 32'd2);
        tick();
        check("hs_add_inst", id_inst, 32'h0022_8333);

        // illegal opcode, rd=0 and rd=31
        drive(1'b1, 32'h0000_007F, 32'h210);
        tick();
        check("ill_flag", {31'b0, id_illegal}, 32'd1);
        check("ill_imm", {29'b0, id_imm_type}, 32'd7);
        check("ill_wen", {31'b0, id_reg_wen}, 32'd0);
        drive(1'b1, 32'h0000_0FFF, 32'h214);
        tick();
        check("ill31_wen", {31'b0, id_reg_wen}, 32'd0);
        check("ill31_ctl", {29'b0, id_mem_rd, id_mem_wr, id_alu_src_imm}, 32'd0);

        // jal x1 and lui x0 decode
        drive(1'b1, 32'h0080_00EF, 32'h218);
        tick();
        check("jal_imm", {29'b0, id_imm_type}, 32'd4);
        check("jal_wen", {31'b0, id_reg_wen}, 32'd1);
        drive(1'b1, 32'h1234_5037, 32'h21C);
        tick();
        check("lui_imm", {29'b0, id_imm_type}, 32'd3);
        check("lui_x0_wen", {31'b0, id_reg_wen}, 32'd0);

        // reset mid-stream
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", {31'b0, id_valid}, 32'd0);
        check("mrst_inst", id_inst, 32'h0000_0013);
        check("mrst_bcnt", bubble_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
